// File: rtl/ex_pkg.sv
// Shared encodings for the execute slot: ALU/FPU function codes, operand-b modes
// and the forwarding-select value that means "use the register-file operand".
package ex_pkg;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_OR    = 3'd3,
    ALU_XOR   = 3'd4,
    ALU_SLT   = 3'd5,
    ALU_SLTU  = 3'd6,
    ALU_PASSB = 3'd7
  } alu_op_e;

  // Codes 7..15 pass operand a through unchanged.
  typedef enum logic [3:0] {
    FPU_ADD = 4'd0,
    FPU_SUB = 4'd1,
    FPU_MUL = 4'd2,
    FPU_MIN = 4'd3,
    FPU_MAX = 4'd4,
    FPU_NEG = 4'd5,
    FPU_ABS = 4'd6
  } fpu_op_e;

  // Modes 4..7 all select load data.
  localparam logic [2:0] ALU_SRC_REG  = 3'd0;
  localparam logic [2:0] ALU_SRC_SLL  = 3'd1;
  localparam logic [2:0] ALU_SRC_SRL  = 3'd2;
  localparam logic [2:0] ALU_SRC_IMM  = 3'd3;
  localparam logic [2:0] ALU_SRC_LOAD = 3'd4;

  localparam int FSEL_NONE = 0;

endpackage

// File: rtl/ex_alu.sv
// Single-cycle integer ALU, purely combinational.
module ex_alu
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_ctrl,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_res
);

  always_comb begin
    o_res = '0;
    case (i_ctrl)
      ALU_ADD:   o_res = i_a + i_b;
      ALU_SUB:   o_res = i_a - i_b;
      ALU_AND:   o_res = i_a & i_b;
      ALU_OR:    o_res = i_a | i_b;
      ALU_XOR:   o_res = i_a ^ i_b;
      ALU_SLT:   o_res = {{(XLEN-1){1'b0}}, $signed(i_a) < $signed(i_b)};
      ALU_SLTU:  o_res = {{(XLEN-1){1'b0}}, i_a < i_b};
      ALU_PASSB: o_res = i_b;
      default:   o_res = '0;
    endcase
  end

endmodule

// File: rtl/ex_fpu_core.sv
// FPU datapath: evaluates the function on entry, then carries the result through
// STAGES enable-gated registers so it lines up with the valid/wreg pipe.
module ex_fpu_core
  import ex_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_en,
  input  logic [3:0]      i_ctrl,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_res
);

  logic [XLEN-1:0]             w_res;
  logic [STAGES:1][XLEN-1:0]   r_res_pipe;

  always_comb begin
    w_res = i_a;
    case (i_ctrl)
      FPU_ADD: w_res = i_a + i_b;
      FPU_SUB: w_res = i_a - i_b;
      FPU_MUL: w_res = i_a * i_b;
      FPU_MIN: w_res = ($signed(i_a) < $signed(i_b)) ? i_a : i_b;
      FPU_MAX: w_res = ($signed(i_a) < $signed(i_b)) ? i_b : i_a;
      FPU_NEG: w_res = -i_a;
      FPU_ABS: w_res = i_a[XLEN-1] ? -i_a : i_a;
      default: w_res = i_a;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_res_pipe <= '0;
    end else if (i_en) begin
      r_res_pipe[1] <= w_res;
      for (int s = 2; s <= STAGES; s++) r_res_pipe[s] <= r_res_pipe[s-1];
    end
  end

  assign o_res = r_res_pipe[STAGES];

endmodule

// File: rtl/fpu_pipe.sv
// FPU core plus its {valid, wreg} shift register. The slot's output register is
// the final latency stage, so this pipe holds FPU_LAT-1 register stages.
module fpu_pipe
  import ex_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int FPU_LAT = 2,
  parameter int REG_W   = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_en,
  input  logic             i_flush,
  input  logic             i_vld,
  input  logic [3:0]       i_ctrl,
  input  logic [XLEN-1:0]  i_a,
  input  logic [XLEN-1:0]  i_b,
  input  logic [REG_W-1:0] i_wreg,
  output logic             o_vld,
  output logic [REG_W-1:0] o_wreg,
  output logic [XLEN-1:0]  o_res
);

  localparam int STAGES = FPU_LAT - 1;

  logic [STAGES:1]             r_vld_pipe;
  logic [STAGES:1][REG_W-1:0]  r_wreg_pipe;

  ex_fpu_core #(.XLEN(XLEN), .STAGES(STAGES)) u_core (
    .clk    (clk),
    .rstn   (rstn),
    .i_en   (i_en),
    .i_ctrl (i_ctrl),
    .i_a    (i_a),
    .i_b    (i_b),
    .o_res  (o_res)
  );

  // Flush only kills valid bits; stale data/wreg behind a zero valid is harmless.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vld_pipe  <= '0;
      r_wreg_pipe <= '0;
    end else if (i_flush) begin
      r_vld_pipe  <= '0;
    end else if (i_en) begin
      r_vld_pipe[1]  <= i_vld;
      r_wreg_pipe[1] <= i_wreg;
      for (int s = 2; s <= STAGES; s++) begin
        r_vld_pipe[s]  <= r_vld_pipe[s-1];
        r_wreg_pipe[s] <= r_wreg_pipe[s-1];
      end
    end
  end

  assign o_vld  = r_vld_pipe[STAGES];
  assign o_wreg = r_wreg_pipe[STAGES];

endmodule

// File: rtl/ex_slot_unit.sv
// One VLIW execute lane: forwarding muxes, single-cycle ALU or pipelined FPU,
// in-order delivery through a valid/ready output register with stall and flush.
module ex_slot_unit
  import ex_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 8,
  parameter int FPU_LAT = 2,
  parameter int REG_W   = 6,
  parameter int FSEL_W  = $clog2(NUM_FWD + 1)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_is_fpu,
  input  logic [2:0]              in_alu_ctrl,
  input  logic [3:0]              in_fpu_ctrl,
  input  logic [2:0]              in_alu_src,
  input  logic [XLEN-1:0]         in_srca,
  input  logic [XLEN-1:0]         in_srcb,
  input  logic [XLEN-1:0]         in_imm,
  input  logic [XLEN-1:0]         in_rdata,
  input  logic [4:0]              in_shamt,
  input  logic [REG_W-1:0]        in_wreg,
  input  logic [FSEL_W-1:0]       in_fsel_a,
  input  logic [FSEL_W-1:0]       in_fsel_b,
  input  logic [NUM_FWD*XLEN-1:0] fwd_data,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_result,
  output logic [REG_W-1:0]        out_wreg,
  output logic                    busy
);

  localparam int IFL_W = $clog2(FPU_LAT + 1);
  localparam logic [FSEL_W-1:0] FSEL_MAX = FSEL_W'(NUM_FWD);

  logic [NUM_FWD:0][XLEN-1:0] w_cand_a, w_cand_b;
  logic [XLEN-1:0]  w_opa, w_fwd_b, w_opb, w_alu_res, w_tail_res;
  logic [REG_W-1:0] w_tail_wreg;
  logic             w_stall, w_acc_alu, w_acc_fpu, w_tail_vld, w_fpu_ret;

  logic [IFL_W-1:0] r_inflight;
  logic             r_out_valid;
  logic [XLEN-1:0]  r_out_result;
  logic [REG_W-1:0] r_out_wreg;

  assign w_cand_a[FSEL_NONE] = in_srca;
  assign w_cand_b[FSEL_NONE] = in_srcb;

  for (genvar k = 0; k < NUM_FWD; k++) begin : g_fwd
    assign w_cand_a[k+1] = fwd_data[k*XLEN +: XLEN];
    assign w_cand_b[k+1] = fwd_data[k*XLEN +: XLEN];
  end

  // Selects beyond the last source fall back to the register-file operand.
  always_comb begin
    w_opa   = in_srca;
    w_fwd_b = in_srcb;
    if (in_fsel_a <= FSEL_MAX) w_opa   = w_cand_a[in_fsel_a];
    if (in_fsel_b <= FSEL_MAX) w_fwd_b = w_cand_b[in_fsel_b];
  end

  always_comb begin
    w_opb = in_rdata;
    case (in_alu_src)
      ALU_SRC_REG: w_opb = w_fwd_b;
      ALU_SRC_SLL: w_opb = w_fwd_b << in_shamt;
      ALU_SRC_SRL: w_opb = w_fwd_b >> in_shamt;
      ALU_SRC_IMM: w_opb = in_imm;
      default:     w_opb = in_rdata;
    endcase
  end

  // ALU ops wait for an empty FPU pipe so results can never reorder.
  assign w_stall   = r_out_valid && !out_ready;
  assign in_ready  = !w_stall && !flush && (in_is_fpu || (r_inflight == '0));
  assign w_acc_alu = in_valid && in_ready && !in_is_fpu;
  assign w_acc_fpu = in_valid && in_ready && in_is_fpu;
  assign w_fpu_ret = w_tail_vld && !w_stall && !flush;

  ex_alu #(.XLEN(XLEN)) u_alu (
    .i_ctrl (in_alu_ctrl),
    .i_a    (w_opa),
    .i_b    (w_opb),
    .o_res  (w_alu_res)
  );

  fpu_pipe #(.XLEN(XLEN), .FPU_LAT(FPU_LAT), .REG_W(REG_W)) u_fpu (
    .clk     (clk),
    .rstn    (rstn),
    .i_en    (!w_stall),
    .i_flush (flush),
    .i_vld   (w_acc_fpu),
    .i_ctrl  (in_fpu_ctrl),
    .i_a     (w_opa),
    .i_b     (w_opb),
    .i_wreg  (in_wreg),
    .o_vld   (w_tail_vld),
    .o_wreg  (w_tail_wreg),
    .o_res   (w_tail_res)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_inflight <= '0;
    end else if (flush) begin
      r_inflight <= '0;
    end else if (w_acc_fpu && !w_fpu_ret) begin
      r_inflight <= r_inflight + IFL_W'(1);
    end else if (!w_acc_fpu && w_fpu_ret) begin
      r_inflight <= r_inflight - IFL_W'(1);
    end
  end

  // Outside a stall the register is either empty or being consumed this cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_wreg   <= '0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
    end else if (!w_stall) begin
      if (w_acc_alu) begin
        r_out_valid  <= 1'b1;
        r_out_result <= w_alu_res;
        r_out_wreg   <= in_wreg;
      end else if (w_fpu_ret) begin
        r_out_valid  <= 1'b1;
        r_out_result <= w_tail_res;
        r_out_wreg   <= w_tail_wreg;
      end else begin
        r_out_valid  <= 1'b0;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_wreg   = r_out_wreg;
  assign busy       = r_out_valid || (r_inflight != '0);

endmodule

// File: tb/tb_ex_slot_unit.sv
// Bench for ex_slot_unit: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a queue-based latency model.
module tb_ex_slot_unit;
  import ex_pkg::*;

  localparam int XLEN    = 32;
  localparam int NUM_FWD = 8;
  localparam int FPU_LAT = 2;
  localparam int REG_W   = 6;
  localparam int FSEL_W  = $clog2(NUM_FWD + 1);

  logic clk = 1'b0, rstn = 1'b0;
  logic in_valid = 1'b0, in_is_fpu = 1'b0, flush = 1'b0, out_ready = 1'b1;
  logic [2:0]  in_alu_ctrl = '0, in_alu_src = '0;
  logic [3:0]  in_fpu_ctrl = '0;
  logic [31:0] in_srca = '0, in_srcb = '0, in_imm = '0, in_rdata = '0;
  logic [4:0]  in_shamt = '0;
  logic [5:0]  in_wreg = '0;
  logic [3:0]  in_fsel_a = '0, in_fsel_b = '0;
  logic [NUM_FWD*32-1:0] fwd_data = '0;
  logic        in_ready, out_valid, busy;
  logic [31:0] out_result;
  logic [5:0]  out_wreg;

  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  ex_slot_unit #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .FPU_LAT(FPU_LAT), .REG_W(REG_W),
                 .FSEL_W(FSEL_W)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_is_fpu(in_is_fpu), .in_alu_ctrl(in_alu_ctrl), .in_fpu_ctrl(in_fpu_ctrl),
    .in_alu_src(in_alu_src), .in_srca(in_srca), .in_srcb(in_srcb), .in_imm(in_imm),
    .in_rdata(in_rdata), .in_shamt(in_shamt), .in_wreg(in_wreg),
    .in_fsel_a(in_fsel_a), .in_fsel_b(in_fsel_b), .fwd_data(fwd_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_wreg(out_wreg), .busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] pick(input logic [3:0] fs, input logic [31:0] rf);
    if (fs == 4'd0 || int'(fs) > NUM_FWD) return rf;
    return fwd_data[(int'(fs) - 1) * 32 +: 32];
  endfunction

  function automatic logic [31:0] opb_m(input logic [31:0] b);
    case (int'(in_alu_src))
      0: return b;
      1: return b << in_shamt;
      2: return b >> in_shamt;
      3: return in_imm;
      default: return in_rdata;
    endcase
  endfunction

  function automatic logic [31:0] alu_m(input int f, input logic [31:0] a, b);
    case (f)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6: return (a < b) ? 32'd1 : 32'd0;
      default: return b;
    endcase
  endfunction

  function automatic logic [31:0] fpu_m(input int f, input logic [31:0] a, b);
    case (f)
      0: return a + b;
      1: return a - b;
      2: return a * b;
      3: return ($signed(a) < $signed(b)) ? a : b;
      4: return ($signed(a) > $signed(b)) ? a : b;
      5: return 32'd0 - a;
      6: return ($signed(a) < 0) ? 32'd0 - a : a;
      default: return a;
    endcase
  endfunction

  // Each op waits cnt unstalled edges before landing in the output register.
  typedef struct { logic [31:0] res; logic [5:0] wreg; int cnt; bit fpu; } op_t;
  op_t pend[$];
  op_t m_new;
  bit          m_ov = 1'b0, m_acc;
  logic [31:0] m_res = '0, a_v, b_v;
  logic [5:0]  m_wreg = '0;

  function automatic int fpu_pend();
    int n = 0;
    foreach (pend[i]) if (pend[i].fpu) n++;
    return n;
  endfunction

  function automatic bit m_ready();
    return !(m_ov && !out_ready) && !flush && (in_is_fpu || fpu_pend() == 0);
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend.delete();
      m_ov = 1'b0; m_res = '0; m_wreg = '0;
    end else if (flush) begin
      pend.delete();
      m_ov = 1'b0;
    end else if (!(m_ov && !out_ready)) begin
      m_acc = in_valid && m_ready();
      m_ov  = 1'b0;
      foreach (pend[i]) pend[i].cnt = pend[i].cnt - 1;
      if (m_acc) begin
        a_v = pick(in_fsel_a, in_srca);
        b_v = opb_m(pick(in_fsel_b, in_srcb));
        m_new.res  = in_is_fpu ? fpu_m(int'(in_fpu_ctrl), a_v, b_v)
                               : alu_m(int'(in_alu_ctrl), a_v, b_v);
        m_new.wreg = in_wreg;
        m_new.fpu  = in_is_fpu;
        m_new.cnt  = in_is_fpu ? FPU_LAT - 1 : 0;
        pend.push_back(m_new);
      end
      if (pend.size() > 0 && pend[0].cnt == 0) begin
        m_ov = 1'b1; m_res = pend[0].res; m_wreg = pend[0].wreg;
        void'(pend.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    chkb("in_ready", in_ready, m_ready());
    chkb("out_valid", out_valid, m_ov);
    chkb("busy", busy, m_ov || pend.size() != 0);
    if (m_ov) begin
      chk("out_result", out_result, m_res);
      chk("out_wreg", 32'(out_wreg), 32'(m_wreg));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_op(input bit fpu, input int f, input logic [31:0] a, b,
                        input logic [5:0] wr);
    in_valid = 1'b1; in_is_fpu = fpu;
    in_alu_ctrl = 3'(f); in_fpu_ctrl = 4'(f);
    in_srca = a; in_srcb = b; in_fsel_a = '0; in_fsel_b = '0;
    in_alu_src = ALU_SRC_REG; in_shamt = '0; in_wreg = wr;
  endtask

  initial begin
    // reset state
    #1;
    chkb("rst out_valid", out_valid, 1'b0);
    chkb("rst busy", busy, 1'b0);
    chk("rst out_result", out_result, 32'd0);
    chk("rst out_wreg", 32'(out_wreg), 32'd0);
    chkb("rst in_ready alu", in_ready, 1'b1);
    in_is_fpu = 1'b1;
    settle();
    chkb("rst in_ready fpu", in_ready, 1'b1);
    step();
    rstn = 1'b1;

    // ALU add 5+7
    set_op(0, ALU_ADD, 32'd5, 32'd7, 6'd9);
    step();
    chkb("add valid", out_valid, 1'b1);
    chk("add result", out_result, 32'd12);
    chk("add wreg", 32'(out_wreg), 32'd9);
    in_valid = 1'b0;
    step();
    chkb("add consumed", out_valid, 1'b0);
    chkb("add busy", busy, 1'b0);

    // forwarding + shifted operand b, then out-of-range select
    fwd_data[2*32 +: 32] = 32'hDEADBEEF;
    set_op(0, ALU_OR, 32'h0, 32'd1, 6'd3);
    in_fsel_a = 4'd3; in_alu_src = ALU_SRC_SLL; in_shamt = 5'd4;
    step();
    chk("fwd or", out_result, 32'hDEADBEFF);
    set_op(0, ALU_OR, 32'h1234, 32'h1, 6'd4);
    in_fsel_a = 4'(NUM_FWD + 1);
    step();
    chk("fsel fallback", out_result, 32'h1235);
    in_valid = 1'b0;
    step();

    // four back-to-back FPU adds, then an ALU op
    for (int i = 0; i < 4; i++) begin
      set_op(1, FPU_ADD, 32'(100 + i), 32'd1000, 6'(i));
      step();
      if (i >= 1) chk("fpu order", out_result, 32'(1100 + i - 1));
    end
    set_op(0, ALU_ADD, 32'd1, 32'd2, 6'd20);
    settle();
    chkb("alu blocked", in_ready, 1'b0);
    step();
    chk("fpu last", out_result, 32'd1103);
    chkb("alu unblocked", in_ready, 1'b1);
    step();
    chk("alu after fpu", out_result, 32'd3);
    chk("alu after fpu wreg", 32'(out_wreg), 32'd20);
    in_valid = 1'b0;
    step();

    // 3-cycle consumer stall with two FPU ops in flight
    set_op(1, FPU_SUB, 32'd50, 32'd8, 6'd1);
    step();
    set_op(1, FPU_MAX, 32'hFFFF_FFFD, 32'd5, 6'd2);
    step();
    chk("stall first", out_result, 32'd42);
    in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chkb("stall in_ready", in_ready, 1'b0);
      step();
      chk("stall hold", out_result, 32'd42);
    end
    out_ready = 1'b1;
    step();
    chk("stall second", out_result, 32'd5);
    chk("stall second wreg", 32'(out_wreg), 32'd2);
    step();
    chkb("stall drained", out_valid, 1'b0);

    // flush one cycle after an FPU accept
    set_op(1, FPU_ADD, 32'd1, 32'd1, 6'd3);
    step();
    in_valid = 1'b0; flush = 1'b1;
    settle();
    chkb("flush in_ready", in_ready, 1'b0);
    step();
    flush = 1'b0;
    chkb("flush out_valid", out_valid, 1'b0);
    chkb("flush busy", busy, 1'b0);
    set_op(0, ALU_XOR, 32'hF0, 32'hFF, 6'd4);
    settle();
    chkb("post flush ready", in_ready, 1'b1);
    step();
    chk("post flush result", out_result, 32'h0F);
    in_valid = 1'b0;
    step();

    // reset during a stall
    out_ready = 1'b0;
    set_op(1, FPU_ADD, 32'd2, 32'd3, 6'd5);
    step();
    set_op(1, FPU_ADD, 32'd4, 32'd4, 6'd6);
    step();
    in_valid = 1'b0;
    step();
    chk("pre reset result", out_result, 32'd5);
    rstn = 1'b0;
    #1;
    chkb("mid reset out_valid", out_valid, 1'b0);
    chkb("mid reset busy", busy, 1'b0);
    chk("mid reset result", out_result, 32'd0);
    step();
    rstn = 1'b1; out_ready = 1'b1;
    set_op(0, ALU_SUB, 32'd10, 32'd3, 6'd7);
    settle();
    chkb("post reset ready", in_ready, 1'b1);
    step();
    chk("post reset result", out_result, 32'd7);
    in_valid = 1'b0;
    step();

    // randomized traffic, checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      in_is_fpu   = 1'($urandom);
      in_alu_ctrl = 3'($urandom);
      in_fpu_ctrl = 4'($urandom);
      in_alu_src  = 3'($urandom);
      in_srca     = $urandom;
      in_srcb     = $urandom;
      in_imm      = $urandom;
      in_rdata    = $urandom;
      in_shamt    = 5'($urandom);
      in_wreg     = 6'($urandom);
      in_fsel_a   = 4'($urandom);
      in_fsel_b   = 4'($urandom);
      for (int k = 0; k < NUM_FWD; k++) fwd_data[k*32 +: 32] = $urandom;
      flush       = ($urandom_range(0, 39) == 0);
      out_ready   = ($urandom_range(0, 9) < 7);
      step();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chkb("final idle", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
